// File: rtl/tsic_cmd_handler_pkg.sv
// Shared types and constants for the TSIC command responder.
package tsic_cmd_handler_pkg;

  localparam int unsigned CMD_W  = 16;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    OP_WR_OFFSET = 4'h0,
    OP_RD_OFFSET = 4'h1,
    OP_WR_GAIN   = 4'h2,
    OP_RD_GAIN   = 4'h3,
    OP_RD_TEMP   = 4'h4
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONV    = 2'd1,
    ST_SEND    = 2'd2,
    ST_WAIT_TX = 2'd3
  } state_e;

  // Command word as delivered by serial_comm
  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [DATA_W-1:0] data;
  } cmd_t;

  localparam logic [OP_W-1:0]  RESP_OK     = 4'hA;
  localparam logic [OP_W-1:0]  RESP_ERR    = 4'hE;
  localparam logic [CMD_W-1:0] ERR_TIMEOUT = 16'hEFFF;

  // Success reply carrying 12 bits of payload
  function automatic logic [CMD_W-1:0] resp_ok(input logic [DATA_W-1:0] d);
    return {RESP_OK, d};
  endfunction

  // Illegal-opcode reply echoing the offending opcode
  function automatic logic [CMD_W-1:0] resp_err_opcode(input logic [OP_W-1:0] op);
    return {RESP_ERR, 8'h00, op};
  endfunction

endpackage

// File: rtl/tsic_cmd_handler_if.sv
// Serial-link handshake plus data_path register/conversion signals.
interface tsic_cmd_handler_if;
  import tsic_cmd_handler_pkg::*;

  logic              cmd_rdy;
  cmd_t              cmd;
  logic              clr_cmd_rdy;
  logic [CMD_W-1:0]  resp;
  logic              snd_resp;
  logic              tx_done;
  logic              conv_start;
  logic              conv_done;
  logic [DATA_W-1:0] temp;
  logic [DATA_W-1:0] offset;
  logic [DATA_W-1:0] gain;

  // serial_comm + data_path side
  modport master (
    output cmd_rdy, cmd, tx_done, conv_done, temp,
    input  clr_cmd_rdy, resp, snd_resp, conv_start, offset, gain
  );

  // Command handler side
  modport slave (
    input  cmd_rdy, cmd, tx_done, conv_done, temp,
    output clr_cmd_rdy, resp, snd_resp, conv_start, offset, gain
  );
endinterface

// File: rtl/tsic_cmd_handler_conv_timer.sv
// Conversion watchdog: clearable, saturating counter with registered timeout flag.
module tsic_cmd_handler_conv_timer #(
  parameter int unsigned CONV_TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int unsigned CNT_W = $clog2(CONV_TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CONV_TIMEOUT - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             timeout_q, timeout_d;

  // Next count: clear wins, otherwise count up to LAST and hold there
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST)) begin
      count_d = count_q + CNT_W'(1);
    end
    timeout_d = (count_d == LAST);
  end

  // Counter and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/tsic_cmd_handler.sv
// TSIC responder: decodes serial commands, runs register ops or a PTAT
// conversion, and returns one response word per command.
module tsic_cmd_handler
  import tsic_cmd_handler_pkg::*;
#(
  parameter int unsigned       CONV_TIMEOUT = 4096,
  parameter logic [DATA_W-1:0] GAIN_RST     = 12'h800
) (
  input  logic               clk,
  input  logic               rst_n,
  tsic_cmd_handler_if.slave  bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] offset_q, offset_d;
  logic [DATA_W-1:0] gain_q, gain_d;
  logic [CMD_W-1:0]  resp_q, resp_d;
  logic              clr_q, clr_d;
  logic              snd_q, snd_d;
  logic              conv_start_q, conv_start_d;
  logic              timer_clr;
  logic              timeout;
  opcode_e           op;
  logic [DATA_W-1:0] data;

  tsic_cmd_handler_conv_timer #(
    .CONV_TIMEOUT (CONV_TIMEOUT)
  ) u_conv_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (timer_clr),
    .en_i      (state_q == ST_CONV),
    .timeout_o (timeout)
  );

  // Next-state, register-write and response decode
  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    gain_d       = gain_q;
    resp_d       = resp_q;
    clr_d        = 1'b0;
    snd_d        = 1'b0;
    conv_start_d = 1'b0;
    timer_clr    = 1'b0;
    op           = opcode_e'(bus.cmd.opcode);
    data         = bus.cmd.data;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_rdy) begin
          clr_d   = 1'b1;
          state_d = ST_SEND;
          case (op)
            OP_WR_OFFSET: begin
              offset_d = data;
              resp_d   = resp_ok(data);
            end
            OP_RD_OFFSET: resp_d = resp_ok(offset_q);
            OP_WR_GAIN: begin
              gain_d = data;
              resp_d = resp_ok(data);
            end
            OP_RD_GAIN: resp_d = resp_ok(gain_q);
            OP_RD_TEMP: begin
              conv_start_d = 1'b1;
              timer_clr    = 1'b1;
              state_d      = ST_CONV;
            end
            default: resp_d = resp_err_opcode(bus.cmd.opcode);
          endcase
        end
      end
      ST_CONV: begin
        // A result arriving on the timeout cycle is still delivered
        if (bus.conv_done) begin
          resp_d  = resp_ok(bus.temp);
          state_d = ST_SEND;
        end else if (timeout) begin
          resp_d  = ERR_TIMEOUT;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        snd_d   = 1'b1;
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (bus.tx_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      offset_q     <= '0;
      gain_q       <= GAIN_RST;
      resp_q       <= '0;
      clr_q        <= 1'b0;
      snd_q        <= 1'b0;
      conv_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      gain_q       <= gain_d;
      resp_q       <= resp_d;
      clr_q        <= clr_d;
      snd_q        <= snd_d;
      conv_start_q <= conv_start_d;
    end
  end

  assign bus.clr_cmd_rdy = clr_q;
  assign bus.resp        = resp_q;
  assign bus.snd_resp    = snd_q;
  assign bus.conv_start  = conv_start_q;
  assign bus.offset      = offset_q;
  assign bus.gain        = gain_q;

endmodule
